gctr_stream: RTL and testbench

GCTR_STREAM -- requirements
Module: gctr_stream

---
 rtl/gctr_stream.sv | 162 ++++++++++++++++
 tb/tb_gctr_stream.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gctr_stream.sv
// GCTR keystream engine: walks a 32-bit counter block through an external block
// cipher and XORs each keystream block with one 128-bit block of the input stream.
module gctr_stream #(
    parameter int KEY_WIDTH = 128,
    parameter int LEN_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [127:0]         icb_in,
    input  logic [KEY_WIDTH-1:0] key_in,
    input  logic                 keyLen,
    input  logic [LEN_WIDTH-1:0] len_in,
    input  logic [127:0]         din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [127:0]         dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [15:0]          dout_keep,
    output logic                 dout_last,
    output logic                 aes_start,
    output logic [127:0]         aes_in,
    output logic [KEY_WIDTH-1:0] aes_key,
    output logic                 aes_keylen,
    input  logic [127:0]         aes_out,
    input  logic                 aes_done,
    output logic                 busy,
    output logic                 done
);

    // ceil(len/16) needs one bit more than the whole-block count
    localparam int BLK_WIDTH = LEN_WIDTH - 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        KS        = 2'd1,
        WAIT_DATA = 2'd2,
        OUT       = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [127:0]           cb_reg;
    logic [127:0]           keystream_reg;
    logic [127:0]           dout_reg;
    logic [KEY_WIDTH-1:0]   key_reg;
    logic                   keylen_reg;
    logic [BLK_WIDTH-1:0]   blocks_left_reg;
    logic [3:0]             tail_reg;
    logic [15:0]            keep_reg;
    logic                   last_reg;
    logic                   aes_start_reg;
    logic                   done_reg;

    logic                   start_msg;
    logic                   start_empty;
    logic                   ks_fire;
    logic                   din_fire;
    logic                   dout_fire;
    logic                   final_block;
    logic [BLK_WIDTH-1:0]   blocks_in;
    logic [15:0]            keep_next;
    logic [127:0]           byte_mask;

    assign start_msg   = (state_reg == IDLE) && start && (len_in != '0);
    assign start_empty = (state_reg == IDLE) && start && (len_in == '0);
    assign ks_fire     = (state_reg == KS) && aes_done;
    assign din_fire    = (state_reg == WAIT_DATA) && din_valid;
    assign dout_fire   = (state_reg == OUT) && dout_ready;
    assign final_block = (blocks_left_reg == BLK_WIDTH'(1));
    assign blocks_in   = BLK_WIDTH'(len_in[LEN_WIDTH-1:4]) + BLK_WIDTH'(|len_in[3:0]);

    // A short final block keeps only its leading tail bytes (byte 0 is the MSB)
    assign keep_next = (final_block && (tail_reg != 4'd0)) ? ~(16'hFFFF >> tail_reg) : 16'hFFFF;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_byte_mask
            assign byte_mask[8*gi +: 8] = {8{keep_next[gi]}};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (start_msg)  state_next = KS;
            KS:        if (aes_done)   state_next = WAIT_DATA;
            WAIT_DATA: if (din_valid)  state_next = OUT;
            OUT:       if (dout_ready) state_next = final_block ? IDLE : KS;
            default:                   state_next = IDLE;
        endcase
    end

    always_comb begin
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE:      busy       = 1'b0;
            WAIT_DATA: din_ready  = 1'b1;
            OUT:       dout_valid = 1'b1;
            default:   busy       = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cb_reg          <= '0;
            keystream_reg   <= '0;
            dout_reg        <= '0;
            key_reg         <= '0;
            keylen_reg      <= 1'b0;
            blocks_left_reg <= '0;
            tail_reg        <= '0;
            keep_reg        <= '0;
            last_reg        <= 1'b0;
            aes_start_reg   <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            // One request per KS entry, whether from IDLE or from the previous OUT
            aes_start_reg <= (state_next == KS) && (state_reg != KS);
            done_reg      <= start_empty || (dout_fire && final_block);
            if (start_msg) begin
                cb_reg          <= icb_in;
                key_reg         <= key_in;
                keylen_reg      <= keyLen;
                blocks_left_reg <= blocks_in;
                tail_reg        <= len_in[3:0];
            end
            if (ks_fire) begin
                keystream_reg <= aes_out;
                cb_reg        <= {cb_reg[127:32], cb_reg[31:0] + 32'd1};
            end
            if (din_fire) begin
                dout_reg <= (din ^ keystream_reg) & byte_mask;
                keep_reg <= keep_next;
                last_reg <= final_block;
            end
            if (dout_fire) begin
                blocks_left_reg <= blocks_left_reg - BLK_WIDTH'(1);
            end
        end
    end

    assign dout       = dout_reg;
    assign dout_keep  = keep_reg;
    assign dout_last  = last_reg;
    assign aes_start  = aes_start_reg;
    assign aes_in     = cb_reg;
    assign aes_key    = key_reg;
    assign aes_keylen = keylen_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_gctr_stream.sv
// Bench for gctr_stream: a behavioural cipher responder plus a scoreboard of
// expected {dout, keep, last} words, one task per scenario.
`timescale 1ns/1ps
module tb_gctr_stream;

    localparam int KW = 128;
    localparam int LW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [127:0]  icb_in;
    logic [KW-1:0] key_in;
    logic          keyLen;
    logic [LW-1:0] len_in;
    logic [127:0]  din;
    logic          din_valid;
    logic          din_ready;
    logic [127:0]  dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [15:0]   dout_keep;
    logic          dout_last;
    logic          aes_start;
    logic [127:0]  aes_in;
    logic [KW-1:0] aes_key;
    logic          aes_keylen;
    logic [127:0]  aes_out;
    logic          aes_done;
    logic          busy;
    logic          done;

    int vectors = 0;
    int miscompares = 0;
    int aes_start_cnt = 0;
    logic [127:0] aes_in_q[$];
    logic [144:0] exp_q[$];

    gctr_stream #(.KEY_WIDTH(KW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .icb_in(icb_in), .key_in(key_in),
        .keyLen(keyLen), .len_in(len_in), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_keep(dout_keep), .dout_last(dout_last),
        .aes_start(aes_start), .aes_in(aes_in), .aes_key(aes_key),
        .aes_keylen(aes_keylen), .aes_out(aes_out), .aes_done(aes_done),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Stand-in cipher: the TC2 known answer, otherwise an arbitrary keyed permutation
    function automatic logic [127:0] cipher_f(input logic [127:0] x, input logic [KW-1:0] k);
        logic [127:0] r;
        if (x == 128'h2 && k == '0) r = 128'h0388dace60b6a392f328c2b971b2fe78;
        else r = {x[95:0], x[127:96]} ^ (k * 128'd3) ^ 128'h0123456789abcdef_fedcba9876543210;
        return r;
    endfunction

    function automatic logic [127:0] inc32(input logic [127:0] c);
        return {c[127:32], c[31:0] + 32'd1};
    endfunction

    function automatic logic [144:0] exp_block(input logic [127:0] cb, input logic [KW-1:0] k,
                                               input logic [127:0] d, input int nbytes, input logic last);
        logic [127:0] m;
        logic [15:0]  kp;
        m  = '0;
        kp = '0;
        for (int b = 0; b < nbytes; b++) begin
            m[127-8*b -: 8] = 8'hFF;
            kp[15-b]        = 1'b1;
        end
        return {(d ^ cipher_f(cb, k)) & m, kp, last};
    endfunction

    initial begin : responder
        logic [127:0] resp;
        aes_done = 1'b0;
        aes_out  = '0;
        forever begin
            @(negedge clk);
            if (aes_start === 1'b1) begin
                aes_in_q.push_back(aes_in);
                aes_start_cnt++;
                resp = cipher_f(aes_in, aes_key);
                repeat (3) @(posedge clk);
                #1;
                aes_out  = resp;
                aes_done = 1'b1;
                @(posedge clk);
                #1;
                aes_done = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_msg(input logic [127:0] icb, input logic [KW-1:0] k, input logic kl,
                             input logic [LW-1:0] len);
        @(negedge clk);
        icb_in = icb;
        key_in = k;
        keyLen = kl;
        len_in = len;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic feed_block(input logic [127:0] d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (din_ready === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            din       = d;
            din_valid = 1'b1;
            @(negedge clk);
            din_valid = 1'b0;
        end
    endtask

    task automatic take_block(output logic [144:0] got, output bit ok, output bit done_seen);
        ok        = 1'b0;
        got       = '0;
        done_seen = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (dout_valid === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            got        = {dout, dout_keep, dout_last};
            dout_ready = 1'b1;
            @(negedge clk);
            dout_ready = 1'b0;
            done_seen  = (done === 1'b1);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({busy, done, aes_start, din_ready, dout_valid, dout_last} !== 6'b0 || dout !== '0 ||
            dout_keep !== '0 || aes_in !== '0 || aes_key !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b done=%b aes_start=%b dout=%h keep=%h aes_in=%h, required all 0",
                     busy, done, aes_start, dout, dout_keep, aes_in);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || din_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: busy=%b din_ready=%b, required 0 0", busy, din_ready);
        end
    endtask

    task automatic test_tc2();
        logic [144:0] got, e;
        bit ok, ok2, dn;
        int base;
        base = aes_in_q.size();
        start_msg(128'h2, '0, 1'b0, 16);
        vectors++;
        if (aes_start !== 1'b1 || aes_in !== 128'h2 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL tc2_aes_start: aes_start=%b aes_in=%h busy=%b, required 1 2 1", aes_start, aes_in, busy);
        end
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (aes_done === 1'b1) ok = 1'b1;
        end
        @(negedge clk);
        vectors++;
        if (!ok || din_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL tc2_din_ready_latency: done_seen=%b din_ready=%b, required 1 1", ok, din_ready);
        end
        exp_q.push_back({128'h0388dace60b6a392f328c2b971b2fe78, 16'hFFFF, 1'b1});
        feed_block('0, ok);
        vectors++;
        if (!ok || dout_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL tc2_dout_latency: fed=%b dout_valid=%b, required 1 1", ok, dout_valid);
        end
        take_block(got, ok2, dn);
        e = exp_q.pop_front();
        vectors++;
        if (!ok2 || got !== e) begin
            miscompares++;
            $display("FAIL tc2_block: got %h required %h", got, e);
        end
        vectors++;
        if (dn !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL tc2_done: done=%b busy=%b, required 1 0", dn, busy);
        end
        vectors++;
        if (aes_in_q.size() != base + 1) begin
            miscompares++;
            $display("FAIL tc2_aes_count: got %0d requests, required 1", aes_in_q.size() - base);
        end
    endtask

    task automatic test_len0();
        int  base;
        bit  seen;
        base = aes_start_cnt;
        start_msg(128'h55, 128'h77, 1'b0, 0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || aes_start !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_done: done=%b busy=%b aes_start=%b, required 1 0 0", done, busy, aes_start);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_pulse_width: done=%b, required 0", done);
        end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (dout_valid !== 1'b0 || aes_start !== 1'b0 || din_ready !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen || aes_start_cnt != base) begin
            miscompares++;
            $display("FAIL len0_quiet: activity=%b aes_starts=%0d, required 0 0", seen, aes_start_cnt - base);
        end
    endtask

    task automatic test_wrap();
        logic [127:0]  icb, cb, d;
        logic [KW-1:0] k;
        logic [144:0]  got, e;
        bit ok, ok2, dn;
        int base;
        icb  = 128'hcafef00d_12345678_9abcdef0_ffffffff;
        k    = 128'h000102030405060708090a0b0c0d0e0f;
        cb   = icb;
        base = aes_in_q.size();
        start_msg(icb, k, 1'b1, 20);
        vectors++;
        if (aes_key !== k || aes_keylen !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_key: aes_key=%h keylen=%b, required %h 1", aes_key, aes_keylen, k);
        end
        for (int b = 0; b < 2; b++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(exp_block(cb, k, d, (b == 1) ? 4 : 16, b == 1));
            cb = inc32(cb);
            feed_block(d, ok);
            take_block(got, ok2, dn);
            e = exp_q.pop_front();
            vectors++;
            if (!ok || !ok2 || got !== e) begin
                miscompares++;
                $display("FAIL wrap_block%0d: got %h required %h", b, got, e);
            end
        end
        vectors++;
        if (got[16:1] !== 16'hF000 || got[112:17] !== '0 || got[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_tail: keep=%h low_bytes=%h last=%b, required f000 0 1", got[16:1], got[112:17], got[0]);
        end
        vectors++;
        if (dn !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_done: done=%b, required 1", dn);
        end
        vectors++;
        if (aes_in_q.size() != base + 2) begin
            miscompares++;
            $display("FAIL wrap_aes_count: got %0d requests, required 2", aes_in_q.size() - base);
        end else begin
            vectors++;
            if (aes_in_q[base] !== icb || aes_in_q[base+1] !== {icb[127:32], 32'h0}) begin
                miscompares++;
                $display("FAIL wrap_counter: aes_in %h then %h, required %h then %h",
                         aes_in_q[base], aes_in_q[base+1], icb, {icb[127:32], 32'h0});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0]  icb, cb, d;
        logic [KW-1:0] k;
        logic [144:0]  got, e, snap;
        bit ok, ok2, dn;
        int base;
        icb  = 128'h0badc0de_00000000_11111111_7ffffffe;
        k    = 128'hfeedface_deadbeef_01234567_89abcdef;
        cb   = icb;
        base = aes_start_cnt;
        start_msg(icb, k, 1'b0, 48);
        for (int b = 0; b < 3; b++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(exp_block(cb, k, d, 16, b == 2));
            cb = inc32(cb);
            feed_block(d, ok);
            if (b == 1) begin
                snap = {dout, dout_keep, dout_last};
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    vectors++;
                    if ({dout, dout_keep, dout_last} !== snap || dout_valid !== 1'b1 ||
                        din_ready !== 1'b0 || aes_start !== 1'b0) begin
                        miscompares++;
                        $display("FAIL stall_cycle%0d: out=%h valid=%b din_ready=%b aes_start=%b, required %h 1 0 0",
                                 c, {dout, dout_keep, dout_last}, dout_valid, din_ready, aes_start, snap);
                    end
                end
            end
            take_block(got, ok2, dn);
            e = exp_q.pop_front();
            vectors++;
            if (!ok || !ok2 || got !== e) begin
                miscompares++;
                $display("FAIL stall_block%0d: got %h required %h", b, got, e);
            end
        end
        vectors++;
        if (dn !== 1'b1 || aes_start_cnt != base + 3) begin
            miscompares++;
            $display("FAIL stall_end: done=%b aes_starts=%0d, required 1 3", dn, aes_start_cnt - base);
        end
    endtask

    task automatic test_busy_start();
        logic [127:0]  icb, cb, d;
        logic [KW-1:0] k;
        logic [144:0]  got, e;
        bit ok, ok2, dn, extra;
        int base, outs;
        icb  = 128'h01020304_05060708_090a0b0c_00000010;
        k    = 128'h13579bdf_2468ace0_0f1e2d3c_4b5a6978;
        cb   = icb;
        base = aes_start_cnt;
        outs = 0;
        start_msg(icb, k, 1'b0, 32);
        icb_in = 128'h99999999_99999999_99999999_99999999;
        key_in = ~k;
        keyLen = 1'b1;
        len_in = 16;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        vectors++;
        if (aes_key !== k || aes_keylen !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_start_key: aes_key=%h keylen=%b busy=%b, required %h 0 1", aes_key, aes_keylen, busy, k);
        end
        for (int b = 0; b < 2; b++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(exp_block(cb, k, d, 16, b == 1));
            cb = inc32(cb);
            feed_block(d, ok);
            take_block(got, ok2, dn);
            if (ok2) outs++;
            e = exp_q.pop_front();
            vectors++;
            if (!ok || !ok2 || got !== e) begin
                miscompares++;
                $display("FAIL busy_start_block%0d: got %h required %h", b, got, e);
            end
        end
        extra = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (dout_valid !== 1'b0 || aes_start !== 1'b0 || busy !== 1'b0) extra = 1'b1;
        end
        vectors++;
        if (dn !== 1'b1 || extra || outs != 2 || aes_start_cnt != base + 2) begin
            miscompares++;
            $display("FAIL busy_start_count: done=%b extra=%b outputs=%0d aes_starts=%0d, required 1 0 2 2",
                     dn, extra, outs, aes_start_cnt - base);
        end
    endtask

    task automatic test_async_reset();
        logic [127:0]  icb, d;
        logic [KW-1:0] k;
        logic [144:0]  got, e;
        bit ok, ok2, dn, stray;
        start_msg(128'h42424242_42424242_42424242_42424242, 128'h5a5a, 1'b1, 32);
        vectors++;
        if (aes_start !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_in_ks: aes_start=%b busy=%b, required 1 1", aes_start, busy);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy, done, aes_start, din_ready, dout_valid, dout_last, aes_keylen} !== 7'b0 ||
            dout !== '0 || dout_keep !== '0 || aes_in !== '0 || aes_key !== '0) begin
            miscompares++;
            $display("FAIL arst_outputs: busy=%b aes_start=%b dout=%h keep=%h aes_in=%h aes_key=%h, required all 0",
                     busy, aes_start, dout, dout_keep, aes_in, aes_key);
        end
        stray = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        vectors++;
        if (stray) begin
            miscompares++;
            $display("FAIL arst_no_done: done or busy seen after abandoned message, required none");
        end
        icb = 128'h00000000_00000000_00000000_00000001;
        k   = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        d   = 128'hdeadbeef_cafebabe_01234567_89abcdef;
        exp_q.push_back(exp_block(icb, k, d, 16, 1'b1));
        start_msg(icb, k, 1'b0, 16);
        feed_block(d, ok);
        take_block(got, ok2, dn);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || !ok2 || got !== e || dn !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_recover: got %h done=%b required %h done=1", got, dn, e);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        icb_in     = '0;
        key_in     = '0;
        keyLen     = 1'b0;
        len_in     = '0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        #1;
        rst = 1'b0;
        test_reset();
        test_tc2();
        test_len0();
        test_wrap();
        test_backpressure();
        test_busy_start();
        test_async_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
